// File: rtl/nrzi_decoder_if.sv
// nrzi_decoder_if: line-sample inputs and decoded-word outputs of the NRZI receiver
interface nrzi_decoder_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             sample_en;
  logic             din;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             stuff_err;
  logic             busy;
  modport master (output en, sample_en, din, input dout, dout_valid, stuff_err, busy);
  modport slave  (input en, sample_en, din, output dout, dout_valid, stuff_err, busy);
endinterface

// File: rtl/nrzi_decoder.sv
// nrzi_decoder: NRZI line decode with bit-unstuffing and LSB-first word assembly
module nrzi_decoder #(
  parameter int WIDTH      = 8,
  parameter int STUFF_LEN  = 6,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  nrzi_decoder_if.slave bus
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int OW = $clog2(STUFF_LEN + 1);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ERR} state_t;
  state_t           r_state;
  logic             r_prev;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_dout;
  logic [BW-1:0]    r_bit_cnt;
  logic [OW-1:0]    r_ones;
  logic             r_dout_valid;
  logic             r_stuff_err;
  logic             w_accept;
  logic             w_bit;
  logic             w_stuff;
  logic             w_last;
  logic [WIDTH-1:0] w_shift;
  assign w_accept = bus.en & bus.sample_en & (r_state != S_ERR);
  assign w_bit    = (bus.din == r_prev);
  assign w_stuff  = (r_ones == OW'(STUFF_LEN));
  assign w_last   = (r_bit_cnt == BW'(WIDTH - 1));
  assign w_shift  = {w_bit, r_shift[WIDTH-1:1]};
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.stuff_err  = r_stuff_err;
  assign bus.busy       = (r_state == S_RUN);
  // Frame FSM: decode each accepted sample, drop stuffed zeros, emit words and stuffing errors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_prev       <= IDLE_LEVEL;
      r_shift      <= '0;
      r_dout       <= '0;
      r_bit_cnt    <= '0;
      r_ones       <= '0;
      r_dout_valid <= 1'b0;
      r_stuff_err  <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      r_stuff_err  <= 1'b0;
      if (!bus.en) begin
        r_state   <= S_IDLE;
        r_prev    <= IDLE_LEVEL;
        r_shift   <= '0;
        r_bit_cnt <= '0;
        r_ones    <= '0;
      end else begin
        if (r_state == S_IDLE) r_state <= S_RUN;
        if (w_accept) begin
          r_prev <= bus.din;
          if (w_stuff) begin
            if (w_bit) begin
              r_stuff_err <= 1'b1;
              r_state     <= S_ERR;
              r_shift     <= '0;
              r_bit_cnt   <= '0;
              r_ones      <= '0;
            end else begin
              r_ones <= '0;
            end
          end else begin
            r_shift <= w_shift;
            r_ones  <= w_bit ? r_ones + 1'b1 : '0;
            if (w_last) begin
              r_dout       <= w_shift;
              r_dout_valid <= 1'b1;
              r_bit_cnt    <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_nrzi_decoder.sv
// tb_nrzi_decoder: table vectors plus encoder-driven sequences, checked through a strobe scoreboard
module tb_nrzi_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  nrzi_decoder_if #(.WIDTH(8)) bus ();
  nrzi_decoder #(.WIDTH(8), .STUFF_LEN(6), .IDLE_LEVEL(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    logic [15:0] din;
    int          n;
    logic [7:0]  word;
    bit          err;
  } vec_t;
  typedef struct {
    bit         err;
    logic [7:0] word;
    int         due;
  } exp_t;
  exp_t       q[$];
  vec_t       tbl[6];
  logic [7:0] last_word = 8'h00;
  logic       enc_lvl;
  int         enc_ones;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Scoreboard: every strobe must match the oldest expectation at the exact due cycle
  always @(negedge clk) begin
    if (bus.dout_valid && bus.stuff_err) chk("strobe_exclusive", 1, 0);
    if (bus.dout_valid || bus.stuff_err) begin
      if (q.size() == 0) begin
        chk(bus.stuff_err ? "unexpected_stuff_err" : "unexpected_dout_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("strobe_kind", {31'd0, bus.stuff_err}, {31'd0, e.err});
        chk("strobe_cycle", cyc, e.due);
        if (!e.err) chk("dout", {24'd0, bus.dout}, {24'd0, e.word});
      end
    end
  end
  task automatic step(input logic se, input logic d, input logic e);
    @(negedge clk);
    bus.en = e;
    bus.sample_en = se;
    bus.din = d;
  endtask
  task automatic push(input bit err, input logic [7:0] w);
    exp_t e;
    e.err = err;
    e.word = w;
    e.due = cyc + 1;
    q.push_back(e);
    if (!err) last_word = w;
  endtask
  task automatic start_enc();
    enc_lvl = 1'b1;
    enc_ones = 0;
  endtask
  task automatic send_byte(input logic [7:0] data, input int gap);
    for (int i = 0; i < 8; i++) begin
      if (enc_ones == 6) begin
        enc_lvl = ~enc_lvl;
        step(1'b1, enc_lvl, 1'b1);
        enc_ones = 0;
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b1);
      end
      if (!data[i]) enc_lvl = ~enc_lvl;
      step(1'b1, enc_lvl, 1'b1);
      if (i == 7) push(1'b0, data);
      enc_ones = data[i] ? enc_ones + 1 : 0;
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b1);
    end
  endtask
  task automatic end_frame();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("busy_idle", {31'd0, bus.busy}, 0);
    chk("dout_hold", {24'd0, bus.dout}, {24'd0, last_word});
  endtask
  initial begin
    bus.en = 1'b0;
    bus.sample_en = 1'b0;
    bus.din = 1'b0;
    tbl[0] = '{16'h00AA, 8, 8'h00, 1'b0};
    tbl[1] = '{16'h00C9, 8, 8'hA5, 1'b0};
    tbl[2] = '{16'h003F, 9, 8'hFF, 1'b0};
    tbl[3] = '{16'h007F, 7, 8'h00, 1'b1};
    tbl[4] = '{16'h00AF, 8, 8'h0F, 1'b0};
    tbl[5] = '{16'h0099, 8, 8'h55, 1'b0};
    repeat (3) @(negedge clk);
    chk("rst_dout", {24'd0, bus.dout}, 0);
    chk("rst_valid", {31'd0, bus.dout_valid}, 0);
    chk("rst_stuff_err", {31'd0, bus.stuff_err}, 0);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < tbl[r].n; i++) begin
        step(1'b1, tbl[r].din[i], 1'b1);
        if (i == tbl[r].n - 1) push(tbl[r].err, tbl[r].word);
      end
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      chk("busy_run", {31'd0, bus.busy}, {31'd0, !tbl[r].err});
      if (tbl[r].err) begin
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("busy_err", {31'd0, bus.busy}, 0);
      end
      end_frame();
    end
    start_enc();
    send_byte(8'hA5, 3);
    end_frame();
    start_enc();
    send_byte(8'hFF, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h3C, 0);
    for (int k = 0; k < 4; k++) send_byte(8'($urandom_range(0, 255)), k & 1);
    step(1'b0, 1'b0, 1'b1);
    chk("busy_multi", {31'd0, bus.busy}, 1);
    end_frame();
    for (int i = 0; i < 7; i++) step(1'b1, tbl[5].din[i], 1'b1);
    step(1'b1, tbl[5].din[7], 1'b0);
    end_frame();
    for (int i = 0; i < 4; i++) step(1'b1, tbl[5].din[i], 1'b1);
    step(1'b0, 1'b0, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("arst_dout", {24'd0, bus.dout}, 0);
    chk("arst_valid", {31'd0, bus.dout_valid}, 0);
    chk("arst_stuff_err", {31'd0, bus.stuff_err}, 0);
    chk("arst_busy", {31'd0, bus.busy}, 0);
    last_word = 8'h00;
    @(negedge clk);
    bus.en = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'(i & 1), 1'b1);
    end_frame();
    start_enc();
    send_byte(8'h00, 0);
    end_frame();
    repeat (5) @(negedge clk);
    chk("drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
